// File: rtl/sdram_ctrl_pkg.sv
// Shared definitions for the SDRAM control-interface slice: host command
// encodings, init sequencer states and default timing constants.
package sdram_ctrl_pkg;

   // Host command encodings (all other codes are reserved)
   localparam logic [2:0] CMD_NOP    = 3'b000;
   localparam logic [2:0] CMD_READA  = 3'b001;
   localparam logic [2:0] CMD_WRITEA = 3'b010;

   // Default timing constants
   localparam int DEF_ASIZE     = 23;
   localparam int DEF_INIT_PER  = 24000;
   localparam int DEF_INIT_GAP  = 20;
   localparam int DEF_INIT_REFS = 8;
   localparam int DEF_REF_PER   = 1024;
   localparam int DEF_MAX_PEND  = 8;

   // Init sequencer states; ST_SREF is only reachable with SELF_REFRESH_EN
   typedef enum logic [2:0] {
      ST_WAIT,
      ST_PRE,
      ST_REF,
      ST_LMR,
      ST_RUN,
      ST_SREF
   } init_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sdram_refresh_budget.sv
// Refresh timer, postponed-refresh counter and sticky overflow flag.
// Counting runs only while RUN is high; LOAD restarts the tick interval.
module sdram_refresh_budget
   import sdram_ctrl_pkg::*;
#(
   parameter int REF_PER  = DEF_REF_PER,
   parameter int MAX_PEND = DEF_MAX_PEND,
   localparam int PW      = $clog2(MAX_PEND + 1)
) (
   input  logic          CLK,
   input  logic          RESET_N,
   input  logic          LOAD,
   input  logic          RUN,
   input  logic          REF_ACK,
   output logic          REF_REQ,
   output logic          REF_URGENT,
   output logic [PW-1:0] REF_PENDING,
   output logic          REF_OVF
);

   localparam int TW = $clog2(REF_PER);
   localparam logic [TW-1:0] RELOAD   = TW'(REF_PER - 1);
   localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

   logic [TW-1:0] timer;
   logic [PW-1:0] pend_next;
   logic          tick;
   logic          ack;
   logic          ovf_set;

   assign tick = RUN && (timer == '0);
   assign ack  = RUN && REF_ACK;

   // Next pending count: a tick and an ack together cancel out
   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latch).
      pend_next = REF_PENDING;
      ovf_set   = 1'b0;
      if (tick && !ack) begin
         if (REF_PENDING == PEND_MAX) ovf_set = 1'b1;
         else                         pend_next = REF_PENDING + 1'b1;
      end else if (ack && !tick && (REF_PENDING != '0)) begin
         pend_next = REF_PENDING - 1'b1;
      end
   end

   // Tick interval timer: reload on LOAD or on reaching zero, frozen otherwise
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!RESET_N)   timer <= '0;
      else if (LOAD)  timer <= RELOAD;
      else if (RUN)   timer <= (timer == '0) ? RELOAD : timer - 1'b1;
   end

   // Pending count and its derived flags all register from pend_next
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         REF_PENDING <= '0;
         REF_REQ     <= 1'b0;
         REF_URGENT  <= 1'b0;
         REF_OVF     <= 1'b0;
      end else begin
         REF_PENDING <= pend_next;
         REF_REQ     <= (pend_next != '0);
         REF_URGENT  <= (pend_next == PEND_MAX);
         if (ovf_set) REF_OVF <= 1'b1;
      end
   end

endmodule

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM control interface: registers/decodes host commands, sequences the
// power-up init (wait, PRECHARGE, REFRESH x INIT_REFS, LOAD_MODE) and hands
// periodic refresh bookkeeping to sdram_refresh_budget.
// Optional macro SELF_REFRESH_EN adds SREF_REQ/SREF_ACTIVE and a SREF state.
module sdram_init_refresh_ctrl
   import sdram_ctrl_pkg::*;
#(
   parameter int ASIZE     = DEF_ASIZE,
   parameter int INIT_PER  = DEF_INIT_PER,
   parameter int INIT_GAP  = DEF_INIT_GAP,
   parameter int INIT_REFS = DEF_INIT_REFS,
   parameter int REF_PER   = DEF_REF_PER,
   parameter int MAX_PEND  = DEF_MAX_PEND,
   localparam int PW       = $clog2(MAX_PEND + 1)
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [2:0]       CMD,
   input  logic [ASIZE-1:0] ADDR,
   input  logic             REF_ACK,
   input  logic             CM_ACK,
   output logic             NOP,
   output logic             READA,
   output logic             WRITEA,
   output logic             REFRESH,
   output logic             PRECHARGE,
   output logic             LOAD_MODE,
   output logic [ASIZE-1:0] SADDR,
   output logic             INIT_REQ,
   output logic             INIT_DONE,
   output logic             REF_REQ,
   output logic             REF_URGENT,
   output logic [PW-1:0]    REF_PENDING,
   output logic             REF_OVF,
`ifdef SELF_REFRESH_EN
   input  logic             SREF_REQ,
   output logic             SREF_ACTIVE,
`endif
   output logic             CMD_ACK
);

   localparam int CW = $clog2(max_int(INIT_PER, INIT_GAP));
   localparam int RW = $clog2(INIT_REFS + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(INIT_PER - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(INIT_GAP - 1);
   localparam logic [RW-1:0] REFS_LAST = RW'(INIT_REFS - 1);

   init_state_t   state;
   logic [CW-1:0] step;
   logic [RW-1:0] ref_cnt;
   logic          in_sref;
   logic          timer_load;
   logic          budget_run;

`ifdef SELF_REFRESH_EN
   assign in_sref    = (state == ST_SREF);
   assign timer_load = (state == ST_LMR && LOAD_MODE) || (in_sref && !SREF_REQ);
`else
   assign in_sref    = 1'b0;
   assign timer_load = (state == ST_LMR && LOAD_MODE);
`endif
   assign budget_run = INIT_DONE && !in_sref;

   // Init sequencer: one step counter spaces every init event
   always_ff @(posedge CLK) begin
      // NOTE: reset is synchronous; every register here is cleared with it.
      if (!RESET_N) begin
         state     <= ST_WAIT;
         step      <= '0;
         ref_cnt   <= '0;
         INIT_REQ  <= 1'b1;
         INIT_DONE <= 1'b0;
         PRECHARGE <= 1'b0;
         REFRESH   <= 1'b0;
         LOAD_MODE <= 1'b0;
`ifdef SELF_REFRESH_EN
         SREF_ACTIVE <= 1'b0;
`endif
      end else begin
         PRECHARGE <= 1'b0;
         REFRESH   <= 1'b0;
         LOAD_MODE <= 1'b0;
         case (state)
            ST_WAIT: begin
               if (step == WAIT_LAST) begin
                  INIT_REQ <= 1'b0;
                  step     <= '0;
                  state    <= ST_PRE;
               end else step <= step + 1'b1;
            end
            ST_PRE: begin
               if (step == GAP_LAST) begin
                  PRECHARGE <= 1'b1;
                  step      <= '0;
                  state     <= ST_REF;
               end else step <= step + 1'b1;
            end
            ST_REF: begin
               if (step == GAP_LAST) begin
                  REFRESH <= 1'b1;
                  step    <= '0;
                  ref_cnt <= ref_cnt + 1'b1;
                  if (ref_cnt == REFS_LAST) state <= ST_LMR;
               end else step <= step + 1'b1;
            end
            ST_LMR: begin
               // The cycle after the LOAD_MODE pulse completes init
               if (LOAD_MODE) begin
                  INIT_DONE <= 1'b1;
                  state     <= ST_RUN;
               end else if (step == GAP_LAST) begin
                  LOAD_MODE <= 1'b1;
                  step      <= '0;
               end else step <= step + 1'b1;
            end
            ST_RUN: begin
`ifdef SELF_REFRESH_EN
               // Self refresh is only entered with no refresh owed
               if (SREF_REQ && (REF_PENDING == '0)) begin
                  SREF_ACTIVE <= 1'b1;
                  state       <= ST_SREF;
               end
`endif
            end
`ifdef SELF_REFRESH_EN
            ST_SREF: begin
               if (!SREF_REQ) begin
                  SREF_ACTIVE <= 1'b0;
                  state       <= ST_RUN;
               end
            end
`endif
            default: state <= ST_WAIT;
         endcase
      end
   end

   // Host command decode, address register and acknowledge pulse
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         SADDR   <= '0;
         NOP     <= 1'b0;
         READA   <= 1'b0;
         WRITEA  <= 1'b0;
         CMD_ACK <= 1'b0;
      end else begin
         SADDR   <= ADDR;
         NOP     <= (CMD == CMD_NOP);
         READA   <= (CMD == CMD_READA)  && INIT_DONE && !in_sref;
         WRITEA  <= (CMD == CMD_WRITEA) && INIT_DONE && !in_sref;
         CMD_ACK <= CM_ACK && !CMD_ACK;
      end
   end

   sdram_refresh_budget #(
      .REF_PER  (REF_PER),
      .MAX_PEND (MAX_PEND)
   ) u_budget (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .LOAD        (timer_load),
      .RUN         (budget_run),
      .REF_ACK     (REF_ACK),
      .REF_REQ     (REF_REQ),
      .REF_URGENT  (REF_URGENT),
      .REF_PENDING (REF_PENDING),
      .REF_OVF     (REF_OVF)
   );

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Bench for sdram_init_refresh_ctrl with INIT_PER=10, INIT_GAP=4,
// INIT_REFS=2, REF_PER=16, MAX_PEND=3. Expected values are queued in edge
// order and compared on the falling edge after the rising edge they name.
module tb_sdram_init_refresh_ctrl;

   localparam int ASIZE = 23;

   logic             CLK;
   logic             RESET_N;
   logic [2:0]       CMD;
   logic [ASIZE-1:0] ADDR;
   logic             REF_ACK;
   logic             CM_ACK;
   logic             NOP, READA, WRITEA;
   logic             REFRESH, PRECHARGE, LOAD_MODE;
   logic [ASIZE-1:0] SADDR;
   logic             INIT_REQ, INIT_DONE;
   logic             REF_REQ, REF_URGENT, REF_OVF;
   logic [1:0]       REF_PENDING;
   logic             CMD_ACK;
`ifdef SELF_REFRESH_EN
   logic             SREF_REQ;
   logic             SREF_ACTIVE;
`endif

   sdram_init_refresh_ctrl #(
      .ASIZE(ASIZE), .INIT_PER(10), .INIT_GAP(4), .INIT_REFS(2),
      .REF_PER(16), .MAX_PEND(3)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .CMD(CMD), .ADDR(ADDR),
      .REF_ACK(REF_ACK), .CM_ACK(CM_ACK),
      .NOP(NOP), .READA(READA), .WRITEA(WRITEA),
      .REFRESH(REFRESH), .PRECHARGE(PRECHARGE), .LOAD_MODE(LOAD_MODE),
      .SADDR(SADDR), .INIT_REQ(INIT_REQ), .INIT_DONE(INIT_DONE),
      .REF_REQ(REF_REQ), .REF_URGENT(REF_URGENT),
      .REF_PENDING(REF_PENDING), .REF_OVF(REF_OVF),
`ifdef SELF_REFRESH_EN
      .SREF_REQ(SREF_REQ), .SREF_ACTIVE(SREF_ACTIVE),
`endif
      .CMD_ACK(CMD_ACK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Edge number since the last reset release (0 while in reset)
   int edge_n = 0;
   always @(posedge CLK) edge_n <= RESET_N ? edge_n + 1 : 0;

   typedef enum {
      S_INIT_REQ, S_PRE, S_REF, S_LMR, S_DONE, S_PEND, S_URG, S_REQ, S_OVF,
      S_NOP, S_READA, S_WRITEA, S_SADDR, S_ACK, S_SREF
   } sig_e;

   typedef struct {
      int          at_edge;
      sig_e        sig;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [31:0] observe(input sig_e s);
      case (s)
         S_INIT_REQ: return {31'b0, INIT_REQ};
         S_PRE:      return {31'b0, PRECHARGE};
         S_REF:      return {31'b0, REFRESH};
         S_LMR:      return {31'b0, LOAD_MODE};
         S_DONE:     return {31'b0, INIT_DONE};
         S_PEND:     return {30'b0, REF_PENDING};
         S_URG:      return {31'b0, REF_URGENT};
         S_REQ:      return {31'b0, REF_REQ};
         S_OVF:      return {31'b0, REF_OVF};
         S_NOP:      return {31'b0, NOP};
         S_READA:    return {31'b0, READA};
         S_WRITEA:   return {31'b0, WRITEA};
         S_SADDR:    return {9'b0, SADDR};
         S_ACK:      return {31'b0, CMD_ACK};
`ifdef SELF_REFRESH_EN
         S_SREF:     return {31'b0, SREF_ACTIVE};
`endif
         default:    return 32'hdead_beef;
      endcase
   endfunction

   // Insert keeping the queue ordered by edge
   function automatic void push_exp(input int at, input sig_e s, input logic [31:0] v);
      exp_t item;
      int   idx;
      item = '{at, s, v};
      idx  = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].at_edge > at) begin
            idx = i;
            break;
         end
      end
      sb.insert(idx, item);
   endfunction

   task automatic do_reset();
      RESET_N = 1'b0;
      CMD     = 3'b000;
      ADDR    = '0;
      REF_ACK = 1'b0;
      CM_ACK  = 1'b0;
`ifdef SELF_REFRESH_EN
      SREF_REQ = 1'b0;
`endif
      sb.delete();
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      RESET_N = 1'b0;
      CMD     = 3'b001;
      ADDR    = 23'h7_1234;
      REF_ACK = 1'b1;
      CM_ACK  = 1'b1;
`ifdef SELF_REFRESH_EN
      SREF_REQ = 1'b1;
`endif
      push_exp(0, S_INIT_REQ, 1);
      push_exp(0, S_DONE, 0);
      push_exp(0, S_PRE, 0);
      push_exp(0, S_SADDR, 0);
      push_exp(0, S_ACK, 0);
      push_exp(0, S_PEND, 0);
      push_exp(0, S_READA, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.at_edge != edge_n || observe(e.sig) !== e.val) begin
               n_err++;
               $display("FAIL reset %s edge %0d: got %0h expected %0h", e.sig.name(), edge_n, observe(e.sig), e.val);
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; n_err++;
         $display("FAIL reset %s: edge %0d never reached", e.sig.name(), e.at_edge);
      end
   endtask

   task automatic test_init_and_refresh();
      exp_t e;
      do_reset();
      for (int k = 1; k <= 28; k++) begin
         push_exp(k, S_INIT_REQ, (k < 10) ? 1 : 0);
         push_exp(k, S_PRE, (k == 14) ? 1 : 0);
         push_exp(k, S_REF, (k == 18 || k == 22) ? 1 : 0);
         push_exp(k, S_LMR, (k == 26) ? 1 : 0);
         push_exp(k, S_DONE, (k >= 27) ? 1 : 0);
      end
      push_exp(42, S_PEND, 0); push_exp(42, S_REQ, 0);
      push_exp(43, S_PEND, 1); push_exp(43, S_REQ, 1);
      push_exp(58, S_PEND, 1); push_exp(59, S_PEND, 2);
      push_exp(74, S_PEND, 2); push_exp(74, S_URG, 0);
      push_exp(75, S_PEND, 3); push_exp(75, S_URG, 1);
      push_exp(90, S_OVF, 0);  push_exp(91, S_OVF, 1);
      push_exp(91, S_PEND, 3); push_exp(91, S_URG, 1);
      for (int i = 0; i < 95; i++) begin
         @(negedge CLK);
         while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.at_edge != edge_n || observe(e.sig) !== e.val) begin
               n_err++;
               $display("FAIL init/refresh %s edge %0d: got %0h expected %0h", e.sig.name(), edge_n, observe(e.sig), e.val);
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; n_err++;
         $display("FAIL init/refresh %s: edge %0d never reached", e.sig.name(), e.at_edge);
      end
   endtask

   task automatic test_ref_ack();
      exp_t e;
      do_reset();
      push_exp(43, S_PEND, 1);
      push_exp(59, S_PEND, 1); push_exp(59, S_REQ, 1);
      push_exp(60, S_PEND, 1);
      push_exp(61, S_PEND, 0); push_exp(61, S_REQ, 0);
      push_exp(63, S_PEND, 0); push_exp(64, S_PEND, 0);
      push_exp(64, S_OVF, 0);
      push_exp(75, S_PEND, 1); push_exp(75, S_URG, 0);
      for (int i = 0; i < 78; i++) begin
         @(negedge CLK);
         while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.at_edge != edge_n || observe(e.sig) !== e.val) begin
               n_err++;
               $display("FAIL ref_ack %s edge %0d: got %0h expected %0h", e.sig.name(), edge_n, observe(e.sig), e.val);
            end
         end
         case (edge_n)
            58, 60, 62: REF_ACK = 1'b1;
            default:    REF_ACK = 1'b0;
         endcase
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; n_err++;
         $display("FAIL ref_ack %s: edge %0d never reached", e.sig.name(), e.at_edge);
      end
   endtask

   task automatic test_decode();
      exp_t e;
      do_reset();
      for (int i = 0; i < 36; i++) begin
         @(negedge CLK);
         while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.at_edge != edge_n || observe(e.sig) !== e.val) begin
               n_err++;
               $display("FAIL decode %s edge %0d: got %0h expected %0h", e.sig.name(), edge_n, observe(e.sig), e.val);
            end
         end
         case (edge_n)
            2: begin
               CMD = 3'b001;
               push_exp(3, S_NOP, 0); push_exp(3, S_READA, 0);
            end
            3: begin
               CMD = 3'b000;
               push_exp(4, S_NOP, 1);
            end
            4: begin
               CMD = 3'b010;
               push_exp(5, S_WRITEA, 0);
            end
            30: begin
               CMD  = 3'b010;
               ADDR = 23'h1_2345;
               push_exp(31, S_WRITEA, 1); push_exp(31, S_SADDR, 32'h1_2345);
               push_exp(31, S_NOP, 0);    push_exp(31, S_READA, 0);
            end
            31: begin
               CMD  = 3'b001;
               ADDR = 23'h0_0abc;
               push_exp(32, S_READA, 1); push_exp(32, S_WRITEA, 0);
               push_exp(32, S_SADDR, 32'h0_0abc);
            end
            32: begin
               CMD = 3'b111;
               push_exp(33, S_NOP, 0); push_exp(33, S_READA, 0); push_exp(33, S_WRITEA, 0);
            end
            33: begin
               CMD = 3'b011;
               push_exp(34, S_NOP, 0); push_exp(34, S_READA, 0); push_exp(34, S_WRITEA, 0);
            end
            34: CMD = 3'b000;
            default: ;
         endcase
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; n_err++;
         $display("FAIL decode %s: edge %0d never reached", e.sig.name(), e.at_edge);
      end
   endtask

   task automatic test_cmd_ack_and_reset();
      exp_t e;
      bit   mid_rst;
      mid_rst = 1'b0;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.at_edge != edge_n || observe(e.sig) !== e.val) begin
               n_err++;
               $display("FAIL ack/restart %s edge %0d: got %0h expected %0h", e.sig.name(), edge_n, observe(e.sig), e.val);
            end
         end
         if (!mid_rst) begin
            case (edge_n)
               4: begin
                  CM_ACK = 1'b1;
                  push_exp(5, S_ACK, 1); push_exp(6, S_ACK, 0);
                  push_exp(7, S_ACK, 1); push_exp(8, S_ACK, 0);
               end
               8: begin
                  CM_ACK = 1'b0;
                  push_exp(9, S_ACK, 0);
                  push_exp(14, S_PRE, 1); push_exp(18, S_REF, 1);
               end
               19: begin
                  RESET_N = 1'b0;
                  mid_rst = 1'b1;
                  push_exp(0, S_INIT_REQ, 1); push_exp(0, S_PRE, 0);
                  push_exp(0, S_REF, 0);      push_exp(0, S_LMR, 0);
                  push_exp(0, S_DONE, 0);     push_exp(0, S_ACK, 0);
               end
               default: ;
            endcase
         end else if (!RESET_N) begin
            RESET_N = 1'b1;
            push_exp(1, S_INIT_REQ, 1);  push_exp(9, S_INIT_REQ, 1);
            push_exp(10, S_INIT_REQ, 0); push_exp(13, S_PRE, 0);
            push_exp(14, S_PRE, 1);      push_exp(15, S_PRE, 0);
            push_exp(15, S_DONE, 0);
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; n_err++;
         $display("FAIL ack/restart %s: edge %0d never reached", e.sig.name(), e.at_edge);
      end
   endtask

`ifdef SELF_REFRESH_EN
   task automatic test_self_refresh();
      exp_t e;
      do_reset();
      push_exp(29, S_SREF, 0);
      push_exp(30, S_SREF, 1);
      for (int k = 35; k <= 80; k += 5) push_exp(k, S_PEND, 0);
      push_exp(80, S_SREF, 1);
      push_exp(81, S_SREF, 0);
      push_exp(96, S_PEND, 0);
      push_exp(97, S_PEND, 1);
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.at_edge != edge_n || observe(e.sig) !== e.val) begin
               n_err++;
               $display("FAIL sref %s edge %0d: got %0h expected %0h", e.sig.name(), edge_n, observe(e.sig), e.val);
            end
         end
         case (edge_n)
            29: SREF_REQ = 1'b1;
            40: begin
               CMD = 3'b001;
               push_exp(41, S_READA, 0);
            end
            41: CMD = 3'b000;
            80: SREF_REQ = 1'b0;
            default: ;
         endcase
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++; n_err++;
         $display("FAIL sref %s: edge %0d never reached", e.sig.name(), e.at_edge);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_init_and_refresh();
      test_ref_ack();
      test_decode();
      test_cmd_ack_and_reset();
`ifdef SELF_REFRESH_EN
      test_self_refresh();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
